// File: rtl/tick_ctrl.sv
// rtl/tick_ctrl.sv - single-clock tick scheduler: main/baud enables, runtime baud divisor, restart watchdog
// Optional feature macro: TICK_CTRL_CFG_EN (runtime divisor handshake and config FSM).
module tick_ctrl #(
    parameter int MAIN_DIV    = 4,
    parameter int BAUD_W      = 16,
    parameter int BAUD_DIV    = 104,
    parameter int TIMER_W     = 24,
    parameter int TIMER_TICKS = 12000000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic              main_en_o,
    output logic              baud_en_o,
    input  logic [BAUD_W-1:0] cfg_div_i,
    input  logic              cfg_valid_i,
    output logic              cfg_ready_o,
    input  logic              timer_arm_i,
    input  logic              timer_kick_i,
    output logic              restart_o
);

    localparam int                 MW    = (MAIN_DIV > 1) ? $clog2(MAIN_DIV) : 1;
    localparam logic [MW-1:0]      MLAST = MW'(MAIN_DIV - 1);
    localparam logic [MW-1:0]      MONE  = MW'(1);
    localparam logic [BAUD_W-1:0]  BDEF  = BAUD_W'(BAUD_DIV);
    localparam logic [BAUD_W-1:0]  BONE  = BAUD_W'(1);
    localparam logic [TIMER_W-1:0] TLAST = TIMER_W'(TIMER_TICKS - 1);
    localparam logic [TIMER_W-1:0] TONE  = TIMER_W'(1);

    logic [MW-1:0]      mcnt;
    logic [BAUD_W-1:0]  bcnt;
    logic [BAUD_W-1:0]  div;
    logic [TIMER_W-1:0] tcnt;
    logic               main_tick;
    logic               baud_tick;
    logic               bcnt_last;

    assign main_tick = (mcnt == MLAST);
    assign bcnt_last = (bcnt == div - BONE);
    assign baud_tick = main_tick && bcnt_last;

    // Enables are forced low while reset is held, even if counters were mid-period.
    assign main_en_o = main_tick & ~rst_i;
    assign baud_en_o = baud_tick & ~rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mcnt <= '0;
        end else if (main_tick) begin
            mcnt <= '0;
        end else begin
            mcnt <= mcnt + MONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bcnt <= '0;
        end else if (main_tick) begin
            bcnt <= bcnt_last ? '0 : bcnt + BONE;
        end
    end

`ifdef TICK_CTRL_CFG_EN
    typedef enum logic {
        C_IDLE,
        C_PEND
    } cstate_t;

    cstate_t           cstate;
    logic [BAUD_W-1:0] pend;

    assign cfg_ready_o = rst_i | (cstate == C_IDLE);

    // A new divisor is only swapped in on a baud boundary so the running period keeps the old one.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cstate <= C_IDLE;
            pend   <= '0;
            div    <= BDEF;
        end else begin
            case (cstate)
                C_IDLE: begin
                    if (cfg_valid_i) begin
                        pend   <= (cfg_div_i == '0) ? BONE : cfg_div_i;
                        cstate <= C_PEND;
                    end
                end
                C_PEND: begin
                    if (baud_tick) begin
                        div    <= pend;
                        cstate <= C_IDLE;
                    end
                end
                default: cstate <= C_IDLE;
            endcase
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg  = ^{cfg_div_i, cfg_valid_i};
    assign div         = BDEF;
    assign cfg_ready_o = 1'b0;
`endif

    typedef enum logic [1:0] {
        W_OFF,
        W_RUN,
        W_FIRED
    } wstate_t;

    wstate_t wstate;
    logic    at_term;

    assign at_term   = (wstate == W_RUN) && main_tick && (tcnt == TLAST);
    // A kick landing on the terminal tick wins over the restart.
    assign restart_o = at_term & ~timer_kick_i & ~rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i || !timer_arm_i) begin
            wstate <= W_OFF;
            tcnt   <= '0;
        end else begin
            case (wstate)
                W_OFF: begin
                    wstate <= W_RUN;
                    tcnt   <= '0;
                end
                W_RUN: begin
                    if (timer_kick_i) begin
                        tcnt <= '0;
                    end else if (main_tick) begin
                        if (tcnt == TLAST) begin
                            wstate <= W_FIRED;
                            tcnt   <= '0;
                        end else begin
                            tcnt <= tcnt + TONE;
                        end
                    end
                end
                W_FIRED: begin
                    tcnt <= '0;
                    if (timer_kick_i) begin
                        wstate <= W_RUN;
                    end
                end
                default: begin
                    wstate <= W_OFF;
                    tcnt   <= '0;
                end
            endcase
        end
    end

endmodule
